// File: rtl/udc_pkg.sv
// Shared definitions for the up/down counter family: boundary mode
// selection and the parameter legality rule used at elaboration time.
package udc_pkg;

  // Behaviour when a count step would cross 0 or MAX_VAL.
  typedef enum logic {
    UDC_WRAP = 1'b0,
    UDC_SAT  = 1'b1
  } udc_mode_e;

  localparam int UDC_MIN_WIDTH = 2;
  localparam int UDC_MAX_WIDTH = 32;

  // True when WIDTH is in the supported range and MAX_VAL fits in
  // 1..2**WIDTH-1. Evaluated as a constant function during elaboration.
  function automatic bit udc_params_ok(input int width, input longint unsigned max_val);
    longint unsigned limit;
    if (width < UDC_MIN_WIDTH || width > UDC_MAX_WIDTH) begin
      return 1'b0;
    end
    limit = (64'd1 << width) - 64'd1;
    return (max_val >= 64'd1) && (max_val <= limit);
  endfunction

endpackage : udc_pkg

// File: rtl/udc_next_calc.sv
// Combinational next-count and boundary-crossing calculation for the
// up/down counter. Everything is done one bit wider than the count so no
// sum or difference is truncated before the boundary decision is made.
//
// A crossing is flagged when the requested step does not fit in the room
// left before the boundary. The resulting value uses the step clamped to
// MAX_VAL, so in wrap mode the result stays inside 0..MAX_VAL even for
// requested steps larger than the whole count range.
module udc_next_calc
  import udc_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter udc_mode_e       MODE    = UDC_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic             up_down,
  output logic [WIDTH-1:0] next,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_W   = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_W};
  // MAX_VAL+1 always fits in WIDTH+1 bits because MAX_VAL <= 2**WIDTH-1.
  localparam logic [WIDTH:0]   MODULUS = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] step_eff;
  logic [WIDTH:0] raw_sum;
  logic [WIDTH:0] eff_sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] wrap_val;

  // Next value and crossing flags for both directions.
  // NOTE: every output and temporary gets a default first, so no path through
  // the branches below leaves a variable unassigned (which would infer a latch).
  always_comb begin
    cnt_ext  = {1'b0, count};
    step_ext = {1'b0, step};
    step_eff = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
    raw_sum  = cnt_ext + step_ext;
    eff_sum  = cnt_ext + step_eff;
    diff     = '0;
    wrap_val = '0;
    next     = count;
    ovf      = 1'b0;
    unf      = 1'b0;

    if (up_down) begin
      if (raw_sum > MAX_EXT) begin
        ovf      = 1'b1;
        wrap_val = (eff_sum >= MODULUS) ? (eff_sum - MODULUS) : eff_sum;
        next     = (MODE == UDC_SAT) ? MAX_W : wrap_val[WIDTH-1:0];
      end else begin
        next = eff_sum[WIDTH-1:0];
      end
    end else begin
      if (step_ext > cnt_ext) begin
        unf      = 1'b1;
        // count + MAX_VAL + 1 - step; equals MODULUS only when count is
        // MAX_VAL and the clamped step is MAX_VAL, which wraps to 0.
        wrap_val = cnt_ext + MODULUS - step_eff;
        if (wrap_val >= MODULUS) begin
          wrap_val = wrap_val - MODULUS;
        end
        next = (MODE == UDC_SAT) ? '0 : wrap_val[WIDTH-1:0];
      end else begin
        diff = cnt_ext - step_ext;
        next = diff[WIDTH-1:0];
      end
    end
  end

endmodule : udc_next_calc

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with wrap or saturate boundaries, load,
// synchronous clear, one-cycle crossing pulses and sticky crossing flags.
// The arithmetic lives in udc_next_calc; this module owns the registers
// and the clear > load > enable priority.
module param_updown_counter
  import udc_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter udc_mode_e       MODE    = UDC_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf_pulse,
  output logic             unf_pulse,
  output logic             ovf_sticky,
  output logic             unf_sticky
);

  // Reject illegal parameter combinations before anything is built.
  if (!udc_params_ok(WIDTH, MAX_VAL)) begin : g_param_check
    $error("param_updown_counter: WIDTH must be 2..32 and MAX_VAL within 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_pulse_q, ovf_pulse_d;
  logic             unf_pulse_q, unf_pulse_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic             unf_sticky_q, unf_sticky_d;

  logic [WIDTH-1:0] calc_next;
  logic             calc_ovf;
  logic             calc_unf;

  udc_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .MODE    (MODE)
  ) u_next_calc (
    .count   (count_q),
    .step    (step),
    .up_down (up_down),
    .next    (calc_next),
    .ovf     (calc_ovf),
    .unf     (calc_unf)
  );

  // Next-state selection: clear beats load, load beats counting.
  always_comb begin
    count_d      = count_q;
    ovf_pulse_d  = 1'b0;
    unf_pulse_d  = 1'b0;
    ovf_sticky_d = ovf_sticky_q;
    unf_sticky_d = unf_sticky_q;

    if (clear) begin
      count_d      = '0;
      ovf_sticky_d = 1'b0;
      unf_sticky_d = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (en) begin
      count_d      = calc_next;
      ovf_pulse_d  = calc_ovf;
      unf_pulse_d  = calc_unf;
      ovf_sticky_d = ovf_sticky_q | calc_ovf;
      unf_sticky_d = unf_sticky_q | calc_unf;
    end
  end

  // State registers, cleared immediately by the asynchronous reset.
  // NOTE: non-blocking assignments here so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      ovf_pulse_q  <= 1'b0;
      unf_pulse_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      ovf_pulse_q  <= ovf_pulse_d;
      unf_pulse_q  <= unf_pulse_d;
      ovf_sticky_q <= ovf_sticky_d;
      unf_sticky_q <= unf_sticky_d;
    end
  end

  assign count      = count_q;
  assign at_max     = (count_q == MAX_W);
  assign at_min     = (count_q == '0);
  assign ovf_pulse  = ovf_pulse_q;
  assign unf_pulse  = unf_pulse_q;
  assign ovf_sticky = ovf_sticky_q;
  assign unf_sticky = unf_sticky_q;

endmodule : param_updown_counter
